// File: rtl/cpu_sequencer.sv
// cpu_sequencer: control FSM that steps the 8-bit multicycle CPU through
// fetch, decode, register read, execute, data-memory access, writeback
// select, writeback and PC update, one strobe per phase.
//
// Handshakes:
// - start is a level. It is honoured only in IDLE and HALT.
// - mem_ready is sampled only while in MEM. A cycle in MEM with
//   mem_ready=1 completes the access.
//
// Optional feature: define CPU_SEQ_MEM_SKIP_EN to let non-memory
// instructions bypass MEM and go straight from EXEC to WBSEL.
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       instruction,
    input  logic             mem_r_en,
    input  logic             mem_w_en,
    input  logic             reg_w_en,
    input  logic             mem_ready,
    output logic [3:0]       state,
    output logic             fetch,
    output logic             decode,
    output logic             reg_rd,
    output logic             execute,
    output logic             access_mem,
    output logic             wb_sel,
    output logic             update_pc,
    output logic             reg_w_strobe,
    output logic             busy,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_REGRD  = 4'd3,
        S_EXEC   = 4'd4,
        S_MEM    = 4'd5,
        S_WBSEL  = 4'd6,
        S_WB     = 4'd7,
        S_PCUPD  = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    state_t            state_q;
    state_t            state_nxt;
    logic              timeout_hit;
    logic              skip_mem;
    logic              wb_q;
    logic [WAIT_W-1:0] wait_cnt;

`ifdef CPU_SEQ_MEM_SKIP_EN
    // Instructions that touch neither read nor write path need no MEM phase.
    assign skip_mem = ~mem_r_en & ~mem_w_en;
`else
    // Enables are not needed for sequencing when every instruction visits MEM.
    logic unused_mem_en;
    assign unused_mem_en = mem_r_en | mem_w_en;
    assign skip_mem      = 1'b0;
`endif

    // Next-state decode; timeout_hit marks the MEM exit caused by the wait limit.
    always_comb begin
        state_nxt   = S_IDLE;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE:   state_nxt = start ? S_FETCH : S_IDLE;
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: state_nxt = (instruction == 8'h00) ? S_HALT : S_REGRD;
            S_REGRD:  state_nxt = S_EXEC;
            S_EXEC:   state_nxt = skip_mem ? S_WBSEL : S_MEM;
            S_MEM: begin
                if (mem_ready) begin
                    state_nxt = S_WBSEL;
                end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    // This is the MEM_TIMEOUT-th consecutive cycle without ready.
                    state_nxt   = S_HALT;
                    timeout_hit = 1'b1;
                end else begin
                    state_nxt = S_MEM;
                end
            end
            S_WBSEL:  state_nxt = S_WB;
            S_WB:     state_nxt = S_PCUPD;
            S_PCUPD:  state_nxt = S_FETCH;
            S_HALT:   state_nxt = start ? S_FETCH : S_HALT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State register, registered phase strobes (decoded from the next state so
    // they line up with the state register), wait counter, error flag, counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            fetch       <= 1'b0;
            decode      <= 1'b0;
            reg_rd      <= 1'b0;
            execute     <= 1'b0;
            access_mem  <= 1'b0;
            wb_sel      <= 1'b0;
            wb_q        <= 1'b0;
            update_pc   <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            mem_timeout <= 1'b0;
            wait_cnt    <= '0;
            instr_count <= '0;
        end else begin
            state_q    <= state_nxt;
            fetch      <= (state_nxt == S_FETCH);
            decode     <= (state_nxt == S_DECODE);
            reg_rd     <= (state_nxt == S_REGRD);
            execute    <= (state_nxt == S_EXEC);
            access_mem <= (state_nxt == S_MEM);
            wb_sel     <= (state_nxt == S_WBSEL);
            wb_q       <= (state_nxt == S_WB);
            update_pc  <= (state_nxt == S_PCUPD);
            busy       <= (state_nxt != S_IDLE) && (state_nxt != S_HALT);
            halted     <= (state_nxt == S_HALT);

            // Wait counter restarts on each MEM entry and counts ready-less cycles.
            if (state_nxt == S_MEM && state_q != S_MEM) begin
                wait_cnt <= '0;
            end else if (state_q == S_MEM && !mem_ready) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            // Sticky until software restarts the core from HALT.
            if (timeout_hit) begin
                mem_timeout <= 1'b1;
            end else if (state_q == S_HALT && start) begin
                mem_timeout <= 1'b0;
            end

            // An instruction retires when its PC update completes.
            if (state_q == S_PCUPD) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    assign state        = state_q;
    assign reg_w_strobe = wb_q & reg_w_en;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: a reset/first-instruction vector table, then
// transaction-level sequences checked against a phase-list reference model.
// CNT_W is reduced so the counter wrap is reachable in a short run.
module tb_cpu_sequencer;

  localparam int TO = 15;
  localparam int CW = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [7:0]    instruction;
  logic          mem_r_en;
  logic          mem_w_en;
  logic          reg_w_en;
  logic          mem_ready;
  logic [3:0]    state;
  logic          fetch, decode, reg_rd, execute, access_mem, wb_sel, update_pc;
  logic          reg_w_strobe, busy, halted, mem_timeout;
  logic [CW-1:0] instr_count;

  cpu_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instruction(instruction),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .reg_w_en(reg_w_en),
    .mem_ready(mem_ready), .state(state), .fetch(fetch), .decode(decode),
    .reg_rd(reg_rd), .execute(execute), .access_mem(access_mem),
    .wb_sel(wb_sel), .update_pc(update_pc), .reg_w_strobe(reg_w_strobe),
    .busy(busy), .halted(halted), .mem_timeout(mem_timeout),
    .instr_count(instr_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_count;
  logic          exp_to;

`ifdef CPU_SEQ_MEM_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_count = '0;
    exp_to    = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Phase strobe pattern {fetch,decode,reg_rd,execute,access_mem,wb_sel,update_pc}.
  function automatic logic [6:0] strobes_of(input int st);
    case (st)
      1:       return 7'b1000000;
      2:       return 7'b0100000;
      3:       return 7'b0010000;
      4:       return 7'b0001000;
      5:       return 7'b0000100;
      6:       return 7'b0000010;
      8:       return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic check_outputs(input string tag, input int exp_st);
    chk({tag, " state"}, 32'(state), 32'(exp_st));
    chk({tag, " strobes"}, 32'({fetch, decode, reg_rd, execute, access_mem, wb_sel, update_pc}),
        32'(strobes_of(exp_st)));
    chk({tag, " busy"}, 32'(busy), 32'(exp_st != 0 && exp_st != 9));
    chk({tag, " halted"}, 32'(halted), 32'(exp_st == 9));
    chk({tag, " mem_timeout"}, 32'(mem_timeout), 32'(exp_to));
    chk({tag, " instr_count"}, 32'(instr_count), 32'(exp_count));
    chk({tag, " reg_w_strobe"}, 32'(reg_w_strobe), 32'(exp_st == 7 && reg_w_en));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst_n;
    logic          start;
    logic [7:0]    instr;
    logic          ready;
    logic          regw;
    int            exp_st;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic run_table();
    vecs.push_back('{1'b0, 1'b0, 8'h21, 1'b1, 1'b0, 0, 0});
    vecs.push_back('{1'b1, 1'b0, 8'h21, 1'b1, 1'b0, 0, 0});
    vecs.push_back('{1'b1, 1'b1, 8'h21, 1'b1, 1'b0, 1, 0});
    vecs.push_back('{1'b1, 1'b0, 8'h21, 1'b1, 1'b1, 2, 0});
    vecs.push_back('{1'b1, 1'b1, 8'h21, 1'b1, 1'b1, 3, 0});
    vecs.push_back('{1'b1, 1'b0, 8'h21, 1'b1, 1'b1, 4, 0});
    if (!SKIP) vecs.push_back('{1'b1, 1'b0, 8'h21, 1'b1, 1'b1, 5, 0});
    vecs.push_back('{1'b1, 1'b0, 8'h21, 1'b1, 1'b1, 6, 0});
    vecs.push_back('{1'b1, 1'b0, 8'h21, 1'b1, 1'b1, 7, 0});
    vecs.push_back('{1'b1, 1'b0, 8'h21, 1'b1, 1'b1, 8, 0});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1, 1});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2, 1});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 9, 1});
    vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 9, 1});
    vecs.push_back('{1'b1, 1'b1, 8'h21, 1'b1, 1'b0, 1, 1});
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    exp_to   = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      rst_n       = vecs[i].rst_n;
      start       = vecs[i].start;
      instruction = vecs[i].instr;
      mem_ready   = vecs[i].ready;
      reg_w_en    = vecs[i].regw;
      step();
      exp_count = vecs[i].exp_cnt;
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_st);
    end
    start = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // From FETCH, list the phases one instruction must visit, given its opcode,
  // its enables and how many cycles memory withholds ready (w >= TO: never).
  // The DUT is then stepped through that list while the bench plays memory.
  task automatic run_instr(input logic [7:0] ins, input int w, input logic r, input logic wr,
                           input logic rw, output int n_mem, output int n_wstb, output bit halted_o);
    logic [3:0] exp_q[$];
    logic [3:0] cur;
    logic [3:0] nxt;
    int         mem_seen;
    exp_q.push_back(4'd2);
    if (ins == 8'h00) begin
      exp_q.push_back(4'd9);
    end else begin
      exp_q.push_back(4'd3);
      exp_q.push_back(4'd4);
      if (SKIP && !r && !wr) begin
        exp_q.push_back(4'd6);
      end else if (w >= TO) begin
        repeat (TO) exp_q.push_back(4'd5);
        exp_q.push_back(4'd9);
      end else begin
        repeat (w + 1) exp_q.push_back(4'd5);
        exp_q.push_back(4'd6);
      end
      if (exp_q[exp_q.size()-1] == 4'd6) begin
        exp_q.push_back(4'd7);
        exp_q.push_back(4'd8);
        exp_q.push_back(4'd1);
      end
    end
    instruction = ins;
    mem_r_en    = r;
    mem_w_en    = wr;
    reg_w_en    = rw;
    cur         = 4'd1;
    mem_seen    = 0;
    n_mem       = 0;
    n_wstb      = 0;
    halted_o    = 1'b0;
    while (exp_q.size() > 0) begin
      nxt   = exp_q.pop_front();
      start = 1'($urandom_range(0, 1));
      if (cur == 4'd5) begin
        mem_ready = (w < TO) && (mem_seen == w);
        mem_seen++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      step();
      if (cur == 4'd8) exp_count++;
      if (cur == 4'd5 && nxt == 4'd9) exp_to = 1'b1;
      check_outputs("model", int'(nxt));
      n_mem  += int'(access_mem);
      n_wstb += int'(reg_w_strobe);
      halted_o = (nxt == 4'd9);
      cur = nxt;
    end
    start = 1'b0;
  endtask

  task automatic resume(input int idle_cycles);
    start = 1'b0;
    repeat (idle_cycles) begin
      step();
      check_outputs("halt_hold", 9);
    end
    start = 1'b1;
    step();
    exp_to = 1'b0;
    check_outputs("resume", 1);
    start = 1'b0;
  endtask

  // ---------------- test ----------------
  int            n_mem, n_wstb;
  bit            hlt;
  logic [7:0]    rnd_ins;
  int            rnd_w;

  initial begin
    rst_n = 1'b0; start = 1'b0; instruction = 8'h00; mem_r_en = 1'b0;
    mem_w_en = 1'b0; reg_w_en = 1'b0; mem_ready = 1'b0;
    exp_count = '0; exp_to = 1'b0;

    run_table();

    // Load with three ready-less cycles: four MEM cycles, one write strobe.
    run_instr(8'h41, 3, 1'b1, 1'b0, 1'b1, n_mem, n_wstb, hlt);
    chk("load access_mem cycles", 32'(n_mem), 32'd4);
    chk("load reg_w_strobe cycles", 32'(n_wstb), 32'd1);

    // Ready arrives on the last allowed MEM cycle: no error.
    run_instr(8'h52, TO - 1, 1'b0, 1'b1, 1'b0, n_mem, n_wstb, hlt);
    chk("ready-wins access_mem cycles", 32'(n_mem), 32'(TO));
    chk("ready-wins halted", 32'(hlt), 32'd0);

    // Ready never arrives: HALT with sticky timeout, cleared by start.
    run_instr(8'h53, TO, 1'b0, 1'b1, 1'b1, n_mem, n_wstb, hlt);
    chk("timeout access_mem cycles", 32'(n_mem), 32'(TO));
    chk("timeout reg_w_strobe cycles", 32'(n_wstb), 32'd0);
    chk("timeout halted", 32'(hlt), 32'd1);
    resume(2);

    // Non-memory instruction: MEM visited only without the skip option.
    run_instr(8'h21, 0, 1'b0, 1'b0, 1'b1, n_mem, n_wstb, hlt);
    chk("nonmem access_mem cycles", 32'(n_mem), SKIP ? 32'd0 : 32'd1);

    // Randomised instruction stream.
    for (int i = 0; i < 40; i++) begin
      rnd_ins = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      rnd_w   = ($urandom_range(0, 5) == 0) ? TO + int'($urandom_range(0, 2))
                                            : int'($urandom_range(0, 4));
      run_instr(rnd_ins, rnd_w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), n_mem, n_wstb, hlt);
      if (hlt) resume(int'($urandom_range(0, 2)));
    end

    // Reset during EXEC with start held high: abort, no retire.
    instruction = 8'h21;
    start = 1'b1;
    step(); check_outputs("pre_rst", 2);
    step(); check_outputs("pre_rst", 3);
    step(); check_outputs("pre_rst", 4);
    rst_n = 1'b0;
    step();
    exp_count = '0;
    exp_to    = 1'b0;
    check_outputs("in_rst", 0);
    rst_n = 1'b1;
    step();
    check_outputs("post_rst", 1);
    start = 1'b0;

    // Counter wrap after 2**CW retired instructions.
    for (int i = 0; i < (1 << CW); i++) begin
      run_instr(8'h5A, 0, 1'b1, 1'b0, 1'b0, n_mem, n_wstb, hlt);
    end
    chk("wrap instr_count", 32'(instr_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Clocked control FSM that drives the 8-bit multicycle CPU through its instruction cycle. The cycle is fetch, decode, register read, execute, data-memory access, writeback select, writeback and PC update. Each phase gets a one-state strobe to the instruction memory, control unit, ALU, data memory and program counter. The block replaces free-running state advancement with a reset-clean sequence that has:
- a start/halt handshake,
- a data-memory ready wait with timeout,
- a retired-instruction counter.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: maximum cycles spent in MEM without `mem_ready` before the timeout error fires.
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `start`, input, 1: level. Begins execution from IDLE or HALT.
- `instruction`, input, 8: instruction register contents, valid from DECODE onward.
- `mem_r_en`, input, 1: control-unit data-memory read enable.
- `mem_w_en`, input, 1: control-unit data-memory write enable.
- `reg_w_en`, input, 1: control-unit register-file write enable.
- `mem_ready`, input, 1: data memory completes access this cycle.
- `state`, output, 4: current FSM state encoding.
- `fetch`, `decode`, `reg_rd`, `execute`, `access_mem`, `wb_sel`, `update_pc`, output, 1 each: phase strobes.
- `reg_w_strobe`, output, 1: register-file write strobe, equal to WB & `reg_w_en`.
- `busy`, output, 1: high in any state other than IDLE and HALT.
- `halted`, output, 1: high in HALT.
- `mem_timeout`, output, 1: sticky error flag.
- `instr_count`, output, `CNT_W`: count of retired instructions.

## Operation
States and encodings:
- IDLE = 0
- FETCH = 1
- DECODE = 2
- REGRD = 3
- EXEC = 4
- MEM = 5
- WBSEL = 6
- WB = 7
- PCUPD = 8
- HALT = 9
- Encodings 10–15 are illegal and go to IDLE on the next edge.

Strobes:
- All strobes are Moore outputs decoded from the state register.
- Each strobe is high for exactly the cycles spent in its state: FETCH→`fetch`, DECODE→`decode`, REGRD→`reg_rd`, EXEC→`execute`, MEM→`access_mem`, WBSEL→`wb_sel`, PCUPD→`update_pc`.

Transitions:
- IDLE: `start`=1 → FETCH, otherwise stay.
- FETCH → DECODE.
- DECODE: `instruction`==8'h00 → HALT (instruction not retired). Otherwise → REGRD.
- REGRD → EXEC → MEM (but see Configuration).
- MEM:
  - `mem_ready`=1 → WBSEL.
  - Otherwise stay and increment the wait counter.
  - If the wait counter reaches `MEM_TIMEOUT` with `mem_ready` still 0 → HALT and set `mem_timeout`.
- MEM with `mem_r_en`=`mem_w_en`=0 still waits for `mem_ready`; memory is expected to ack immediately.
- WBSEL → WB → PCUPD.
- PCUPD: increment `instr_count` (wraps at 2^`CNT_W`). Then → FETCH.
- HALT: `start`=1 → FETCH and clear `mem_timeout`. Otherwise stay.

Other rules:
- `start` is ignored in every state except IDLE and HALT.
- The wait counter is `clog2(MEM_TIMEOUT+1)` bits and clears on every entry to MEM.

## Timing
Reset values:
- `rst_n`=0 at a rising edge: next state IDLE.
- All strobes, `busy`, `halted` and `mem_timeout` are 0; `instr_count` is 0; the wait counter is 0.
- Reset mid-instruction aborts it with no retire.

Latency:
- `start` sampled high in IDLE → `fetch` high the next cycle.
- Instruction with zero memory wait: FETCH to PCUPD is 8 cycles, so the next FETCH comes 8 cycles after the previous one.
- Each cycle `mem_ready` is low in MEM adds one cycle.

Boundary behaviour:
- Timeout: `mem_ready` low for `MEM_TIMEOUT` consecutive MEM cycles → HALT at the following edge, and `mem_timeout` rises with `halted`.
- `mem_ready` high in the same cycle the timeout count is reached: ready wins, go to WBSEL, no error.
- Halt at DECODE: `instruction`==0 → `halted` asserts 2 cycles after `fetch`. `instr_count` is unchanged.

## Configuration
Macro `CPU_SEQ_MEM_SKIP_EN`:
- Defined: EXEC with `mem_r_en`=`mem_w_en`=0 goes directly to WBSEL. Non-memory instructions take 7 cycles FETCH to FETCH, and `access_mem` never pulses for them.
- Undefined: EXEC always goes to MEM. Non-memory instructions take 8 cycles (with immediate `mem_ready`).

## Test plan
- Reset then `start` pulse, `instruction`=8'h21, `mem_ready`=1, no memory enables → strobe sequence `fetch`, `decode`, `reg_rd`, `execute`, `access_mem`, `wb_sel`, WB, `update_pc` on consecutive cycles (`access_mem` omitted with the skip macro), then `instr_count`=1 and `fetch` again.
- `instruction`=8'h00 at DECODE → `halted`=1, `busy`=0, `instr_count` unchanged. `start`=1 → `fetch` next cycle.
- Load (`mem_r_en`=1) with `mem_ready` low 3 cycles → `access_mem` high 4 cycles, then WBSEL. `reg_w_en`=1 → `reg_w_strobe` high exactly 1 cycle.
- `mem_w_en`=1 with `mem_ready` held 0 → HALT after 15 MEM cycles, `mem_timeout`=1. `start` clears it.
- `rst_n`=0 asserted during EXEC → IDLE next edge, all outputs 0, `instr_count`=0. `start` held high during FETCH–PCUPD has no effect.
- Run 65536 non-halting instructions → `instr_count` wraps to 0.
